// File: rtl/time_entry_loader_pkg.sv
// Shared types and constants for the keypad-to-countdown time entry loader.
package time_entry_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int BCD_W            = 4;
  localparam int NUM_DIGITS       = 4;
  localparam int DIGIT_MAX        = 9;
  localparam int SEC_TENS_MAX_DEF = 5;
  localparam int DIGITS_W         = BCD_W * NUM_DIGITS;
  localparam int CNT_W            = 3;
  localparam int LOAD_CNT_W       = 2;

  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return code <= BCD_W'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/time_entry_loader_if.sv
// Keypad/control inputs and counter-load/status outputs of the time entry loader.
interface time_entry_loader_if;
  import time_entry_loader_pkg::*;

  logic                 key_valid;
  logic [BCD_W-1:0]     key_code;
  logic                 start;
  logic                 cancel;
  logic                 done;
  logic [DIGITS_W-1:0]  digits;
  logic                 loadn;
  logic                 busy;
  logic                 entry_err;
  logic [CNT_W-1:0]     digit_cnt;

  modport master (
    output key_valid, key_code, start, cancel, done,
    input  digits, loadn, busy, entry_err, digit_cnt
  );

  modport slave (
    input  key_valid, key_code, start, cancel, done,
    output digits, loadn, busy, entry_err, digit_cnt
  );

endinterface

// File: rtl/time_entry_loader_check.sv
// Combinational MM:SS validation; normalizes seconds >= 60 into minutes when
// TIME_ENTRY_NORMALIZE_EN is defined.
module time_entry_check
  import time_entry_loader_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
  input  logic [DIGITS_W-1:0] digits,
  output logic                valid,
  output logic                is_zero,
  output logic [DIGITS_W-1:0] norm_digits
);

  logic [BCD_W-1:0] sec_t;
  logic             sec_ok;

  assign sec_t   = digits[7:4];
  assign sec_ok  = sec_t <= BCD_W'(SEC_TENS_MAX);
  assign is_zero = (digits == '0);

`ifdef TIME_ENTRY_NORMALIZE_EN
  logic [BCD_W-1:0] min_t;
  logic [BCD_W-1:0] min_u;

  assign min_t = digits[15:12];
  assign min_u = digits[11:8];

  // Only 6x..9x seconds can fold into minutes; 99 minutes has no room for the carry.
  always_comb begin
    valid       = sec_ok;
    norm_digits = digits;
    if (!sec_ok && (sec_t >= 4'd6)) begin
      if ((min_t == 4'd9) && (min_u == 4'd9)) begin
        valid = 1'b0;
      end else begin
        valid            = 1'b1;
        norm_digits[7:4] = sec_t - 4'd6;
        if (min_u == 4'd9) begin
          norm_digits[15:12] = min_t + 4'd1;
          norm_digits[11:8]  = 4'd0;
        end else begin
          norm_digits[11:8]  = min_u + 4'd1;
        end
      end
    end
  end
`else
  assign valid       = sec_ok;
  assign norm_digits = digits;
`endif

endmodule

// File: rtl/time_entry_loader.sv
// Keypad time entry and parallel load of the BCD countdown chain.
// Optional seconds normalization: define TIME_ENTRY_NORMALIZE_EN.
//
//   state  | meaning
//   IDLE   | cleared, waiting for first digit
//   ENTRY  | collecting digits, start triggers validation
//   LOAD   | loadn held low, digits frozen
//   LOCKED | countdown running, waiting for done
module time_entry_loader
  import time_entry_loader_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int LOAD_CYCLES  = 1
) (
  input logic                clk,
  input logic                clrn,
  time_entry_loader_if.slave bus
);

  state_t                state_q, state_d;
  logic [DIGITS_W-1:0]   digits_q, digits_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOAD_CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic                  loadn_q, loadn_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  chk_valid;
  logic                  chk_zero;
  logic [DIGITS_W-1:0]   chk_norm;
  logic                  key_ok;

  time_entry_check #(
    .SEC_TENS_MAX (SEC_TENS_MAX)
  ) u_check (
    .digits      (digits_q),
    .valid       (chk_valid),
    .is_zero     (chk_zero),
    .norm_digits (chk_norm)
  );

  assign key_ok = bus.key_valid && is_digit(bus.key_code) &&
                  (cnt_q < CNT_W'(NUM_DIGITS));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      digits_q   <= '0;
      cnt_q      <= '0;
      load_cnt_q <= '0;
      loadn_q    <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      cnt_q      <= cnt_d;
      load_cnt_q <= load_cnt_d;
      loadn_q    <= loadn_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    cnt_d      = cnt_q;
    load_cnt_d = load_cnt_q;
    loadn_d    = loadn_q;
    err_d      = 1'b0;

    if (bus.cancel) begin
      state_d    = ST_IDLE;
      digits_d   = '0;
      cnt_d      = '0;
      load_cnt_d = '0;
      loadn_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_ENTRY: begin
          // An accepted start swallows any key arriving in the same cycle.
          if (bus.start && (state_q == ST_ENTRY)) begin
            if (chk_valid && !chk_zero) begin
              state_d    = ST_LOAD;
              digits_d   = chk_norm;
              loadn_d    = 1'b0;
              load_cnt_d = LOAD_CNT_W'(LOAD_CYCLES - 1);
            end else begin
              state_d  = ST_IDLE;
              digits_d = '0;
              cnt_d    = '0;
              err_d    = 1'b1;
            end
          end else if (key_ok) begin
            state_d  = ST_ENTRY;
            digits_d = {digits_q[DIGITS_W-BCD_W-1:0], bus.key_code};
            cnt_d    = cnt_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_cnt_q == '0) begin
            state_d = ST_LOCKED;
            loadn_d = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q - 1'b1;
          end
        end
        ST_LOCKED: begin
          if (bus.done) begin
            state_d  = ST_IDLE;
            digits_d = '0;
            cnt_d    = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_LOCKED);
  end

  assign bus.digits    = digits_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.loadn     = loadn_q;
  assign bus.busy      = busy_q;
  assign bus.entry_err = err_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// Scoreboard bench for time_entry_loader with default parameters (LOAD_CYCLES=1).
module tb_time_entry_loader;

  logic clk = 1'b0;
  logic clrn;

  always #5 clk = ~clk;

  time_entry_loader_if bus();

  time_entry_loader dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [15:0] d;
    logic [2:0]  c;
    logic        ld;
    logic        bz;
    logic        er;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  task automatic drive_idle();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    bus.start     = 1'b0;
    bus.cancel    = 1'b0;
    bus.done      = 1'b0;
  endtask

  task automatic step(input string tag, input logic kv, input logic [3:0] kc,
                      input logic st, input logic cn, input logic dn,
                      input logic [15:0] d, input logic [2:0] c,
                      input logic ld, input logic bz, input logic er);
    exp_t e;
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.start     = st;
    bus.cancel    = cn;
    bus.done      = dn;
    e.tag = tag; e.d = d; e.c = c; e.ld = ld; e.bz = bz; e.er = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive_idle();
    e = sb.pop_front();
    check_eq({e.tag, ".digits"}, 32'(bus.digits), 32'(e.d));
    check_eq({e.tag, ".cnt"},    32'(bus.digit_cnt), 32'(e.c));
    check_eq({e.tag, ".loadn"},  32'(bus.loadn), 32'(e.ld));
    check_eq({e.tag, ".busy"},   32'(bus.busy), 32'(e.bz));
    check_eq({e.tag, ".err"},    32'(bus.entry_err), 32'(e.er));
  endtask

  task automatic key(input string tag, input logic [3:0] k, input logic [15:0] d, input logic [2:0] c);
    step(tag, 1'b1, k, 1'b0, 1'b0, 1'b0, d, c, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    drive_idle();
    clrn = 1'b1;
    #1 clrn = 1'b0;
    #2;
    check_eq("rst.digits", 32'(bus.digits), 32'h0);
    check_eq("rst.cnt",    32'(bus.digit_cnt), 32'h0);
    check_eq("rst.loadn",  32'(bus.loadn), 32'h1);
    check_eq("rst.busy",   32'(bus.busy), 32'h0);
    check_eq("rst.err",    32'(bus.entry_err), 32'h0);
    #9 clrn = 1'b1;
    @(posedge clk);
    #1;

    // Normal entry, load, lock, done
    key("a_k1", 4'd1, 16'h0001, 3'd1);
    key("a_k2", 4'd2, 16'h0012, 3'd2);
    key("a_k3", 4'd3, 16'h0123, 3'd3);
    key("a_k0", 4'd0, 16'h1230, 3'd4);
    step("a_start",  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h1230, 3'd4, 1'b0, 1'b1, 1'b0);
    step("a_locked", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1230, 3'd4, 1'b1, 1'b1, 1'b0);
    step("a_key9",   1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 16'h1230, 3'd4, 1'b1, 1'b1, 1'b0);
    step("a_st_lk",  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h1230, 3'd4, 1'b1, 1'b1, 1'b0);
    step("a_done",   1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

    // Fifth digit and non-digit code ignored; done ignored outside LOCKED
    key("b_k1", 4'd1, 16'h0001, 3'd1);
    key("b_k2", 4'd2, 16'h0012, 3'd2);
    key("b_k3", 4'd3, 16'h0123, 3'd3);
    key("b_k4", 4'd4, 16'h1234, 3'd4);
    key("b_k5", 4'd5, 16'h1234, 3'd4);
    key("b_k12", 4'd12, 16'h1234, 3'd4);
    step("b_done",   1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h1234, 3'd4, 1'b1, 1'b0, 1'b0);
    step("b_cancel", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

    // Seconds-tens 7
    key("c_k0", 4'd0, 16'h0000, 3'd1);
    key("c_k7", 4'd7, 16'h0007, 3'd2);
    key("c_k5", 4'd5, 16'h0075, 3'd3);
`ifdef TIME_ENTRY_NORMALIZE_EN
    step("c_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0115, 3'd3, 1'b0, 1'b1, 1'b0);
    step("c_lock",  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0115, 3'd3, 1'b1, 1'b1, 1'b0);
    step("c_done",  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
`else
    step("c_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1);
    step("c_after", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
`endif

    // Zero value: ignored in IDLE, rejected in ENTRY
    step("d_st_idle", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
    key("d_k12", 4'd12, 16'h0000, 3'd0);
    key("d_k0a", 4'd0, 16'h0000, 3'd1);
    key("d_k0b", 4'd0, 16'h0000, 3'd2);
    step("d_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1);
    step("d_after", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

    // Start and cancel together
    key("e_k4", 4'd4, 16'h0004, 3'd1);
    key("e_k5", 4'd5, 16'h0045, 3'd2);
    step("e_st_cn", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
    step("e_after", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

    // Seconds-tens at the limit, key dropped with accepted start, cancel in LOCKED
    key("h_k5", 4'd5, 16'h0005, 3'd1);
    key("h_k9", 4'd9, 16'h0059, 3'd2);
    step("h_st_key", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0059, 3'd2, 1'b0, 1'b1, 1'b0);
    step("h_lock",   1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0059, 3'd2, 1'b1, 1'b1, 1'b0);
    step("h_cancel", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

    // Seconds-tens 6
    key("i_k6", 4'd6, 16'h0006, 3'd1);
    key("i_k0", 4'd0, 16'h0060, 3'd2);
`ifdef TIME_ENTRY_NORMALIZE_EN
    step("i_start",  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0100, 3'd2, 1'b0, 1'b1, 1'b0);
    step("i_cancel", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);
`else
    step("i_start",  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b1);
`endif

    // Cancel mid-LOAD
    key("f_k1", 4'd1, 16'h0001, 3'd1);
    key("f_k0", 4'd0, 16'h0010, 3'd2);
    step("f_start",  1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0010, 3'd2, 1'b0, 1'b1, 1'b0);
    step("f_cancel", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0);

    // Async reset mid-LOAD
    key("g_k2", 4'd2, 16'h0002, 3'd1);
    key("g_k0", 4'd0, 16'h0020, 3'd2);
    step("g_start", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0020, 3'd2, 1'b0, 1'b1, 1'b0);
    #2 clrn = 1'b0;
    #1;
    check_eq("g_rst.loadn",  32'(bus.loadn), 32'h1);
    check_eq("g_rst.digits", 32'(bus.digits), 32'h0);
    check_eq("g_rst.busy",   32'(bus.busy), 32'h0);
    check_eq("g_rst.cnt",    32'(bus.digit_cnt), 32'h0);
    #1 clrn = 1'b1;
    key("g_k3", 4'd3, 16'h0003, 3'd1);
    step("g_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0003, 3'd1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
